// File: rtl/byte_striping.sv
// Transmit-side byte striper: pairs an incoming byte stream onto two lanes and
// flushes a trailing lone lane-0 byte after FLUSH_CYCLES idle cycles.
module byte_striping #(
   parameter int FLUSH_CYCLES = 4,
   parameter int CNT_W        = 8
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [7:0]       data_in,
   input  logic             valid_in,
   output logic [7:0]       data_stripe_0,
   output logic [7:0]       data_stripe_1,
   output logic             valid_stripe_0,
   output logic             valid_stripe_1,
   output logic [CNT_W-1:0] pair_count
);

   localparam int IDLE_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [7:0]        stage0, stage0_nx;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_nx;
   logic [7:0]        data_0_nx, data_1_nx;
   logic              valid_0_nx, valid_1_nx;
   logic [CNT_W-1:0]  count_nx;
   logic              timeout;

   // The current idle edge is the FLUSH_CYCLES-th one after the capture edge.
   assign timeout = (FLUSH_CYCLES > 0) && (idle_cnt == IDLE_W'(FLUSH_CYCLES - 1));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nx    = state;
      stage0_nx   = stage0;
      idle_cnt_nx = idle_cnt;
      data_0_nx   = data_stripe_0;
      data_1_nx   = data_stripe_1;
      valid_0_nx  = 1'b0;
      valid_1_nx  = 1'b0;
      count_nx    = pair_count;

      case (state)
         EMPTY: begin
            if (valid_in) begin
               stage0_nx   = data_in;
               idle_cnt_nx = '0;
               state_nx    = HALF;
            end
         end
         HALF: begin
            // Pairing takes priority over a timeout landing on the same edge.
            if (valid_in) begin
               data_0_nx   = stage0;
               data_1_nx   = data_in;
               valid_0_nx  = 1'b1;
               valid_1_nx  = 1'b1;
               count_nx    = pair_count + 1'b1;
               idle_cnt_nx = '0;
               state_nx    = EMPTY;
            end else if (timeout) begin
               data_0_nx   = stage0;
               data_1_nx   = 8'h00;
               valid_0_nx  = 1'b1;
               count_nx    = pair_count + 1'b1;
               idle_cnt_nx = '0;
               state_nx    = EMPTY;
            end else begin
               idle_cnt_nx = idle_cnt + 1'b1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
         state          <= EMPTY;
         stage0         <= 8'h00;
         idle_cnt       <= '0;
         data_stripe_0  <= 8'h00;
         data_stripe_1  <= 8'h00;
         valid_stripe_0 <= 1'b0;
         valid_stripe_1 <= 1'b0;
         pair_count     <= '0;
      end else begin
         state          <= state_nx;
         stage0         <= stage0_nx;
         idle_cnt       <= idle_cnt_nx;
         data_stripe_0  <= data_0_nx;
         data_stripe_1  <= data_1_nx;
         valid_stripe_0 <= valid_0_nx;
         valid_stripe_1 <= valid_1_nx;
         pair_count     <= count_nx;
      end
   end

endmodule

// File: tb/tb_byte_striping.sv
// Directed-vector bench for byte_striping: per-cycle expected table, lane
// reassembly scoreboard, a narrow-counter instance and an async mid-pair reset.
module tb_byte_striping;

   logic       clk_2f;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_stripe_0, data_stripe_1;
   logic       valid_stripe_0, valid_stripe_1;
   logic [7:0] pair_count;
   logic [7:0] n_data_0, n_data_1;
   logic       n_valid_0, n_valid_1;
   logic [1:0] n_count;

   int errors = 0;
   int checks = 0;

   byte_striping #(.FLUSH_CYCLES(4), .CNT_W(8)) dut (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .data_stripe_0(data_stripe_0), .data_stripe_1(data_stripe_1),
      .valid_stripe_0(valid_stripe_0), .valid_stripe_1(valid_stripe_1),
      .pair_count(pair_count)
   );

   // Same stimulus, 2-bit counter to exercise the wrap.
   byte_striping #(.FLUSH_CYCLES(4), .CNT_W(2)) dut_narrow (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .data_stripe_0(n_data_0), .data_stripe_1(n_data_1),
      .valid_stripe_0(n_valid_0), .valid_stripe_1(n_valid_1),
      .pair_count(n_count)
   );

   initial begin
      clk_2f = 1'b0;
      forever #5 clk_2f = ~clk_2f;
   end

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ev0;
      logic       ev1;
      logic [7:0] ed0;
      logic [7:0] ed1;
      logic [7:0] ecnt;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] sent[$];
   logic [7:0] recovered[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic ev0, input logic ev1,
                      input logic [7:0] ed0, input logic [7:0] ed1, input logic [7:0] ecnt);
      vec_t t;
      t.v = v; t.d = d; t.ev0 = ev0; t.ev1 = ev1; t.ed0 = ed0; t.ed1 = ed1; t.ecnt = ecnt;
      vq.push_back(t);
   endtask

   task automatic check_all(input string tag, input logic ev0, input logic ev1,
                            input logic [7:0] ed0, input logic [7:0] ed1, input logic [7:0] ecnt);
      check({tag, ".valid0"}, 32'(valid_stripe_0), 32'(ev0));
      check({tag, ".valid1"}, 32'(valid_stripe_1), 32'(ev1));
      check({tag, ".data0"}, 32'(data_stripe_0), 32'(ed0));
      check({tag, ".data1"}, 32'(data_stripe_1), 32'(ed1));
      check({tag, ".count"}, 32'(pair_count), 32'(ecnt));
      check({tag, ".count_w2"}, 32'(n_count), 32'(ecnt[1:0]));
   endtask

   initial begin
      logic [7:0] exp_b;
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;

      //   v  data   v0 v1  d0     d1     cnt
      // stream 01..04
      add(1, 8'h01, 0, 0, 8'h00, 8'h00, 8'd0);
      add(1, 8'h02, 1, 1, 8'h01, 8'h02, 8'd1);
      add(1, 8'h03, 0, 0, 8'h01, 8'h02, 8'd1);
      add(1, 8'h04, 1, 1, 8'h03, 8'h04, 8'd2);
      // lone 5A flushed on the 4th idle edge
      add(1, 8'h5A, 0, 0, 8'h03, 8'h04, 8'd2);
      add(0, 8'h00, 0, 0, 8'h03, 8'h04, 8'd2);
      add(0, 8'h00, 0, 0, 8'h03, 8'h04, 8'd2);
      add(0, 8'h00, 0, 0, 8'h03, 8'h04, 8'd2);
      add(0, 8'h00, 1, 0, 8'h5A, 8'h00, 8'd3);
      add(0, 8'h00, 0, 0, 8'h5A, 8'h00, 8'd3);
      // partner one edge before the timeout edge
      add(1, 8'h11, 0, 0, 8'h5A, 8'h00, 8'd3);
      add(0, 8'h00, 0, 0, 8'h5A, 8'h00, 8'd3);
      add(0, 8'h00, 0, 0, 8'h5A, 8'h00, 8'd3);
      add(1, 8'h22, 1, 1, 8'h11, 8'h22, 8'd4);
      // partner exactly on the timeout edge: pairing wins
      add(1, 8'h33, 0, 0, 8'h11, 8'h22, 8'd4);
      add(0, 8'h00, 0, 0, 8'h11, 8'h22, 8'd4);
      add(0, 8'h00, 0, 0, 8'h11, 8'h22, 8'd4);
      add(0, 8'h00, 0, 0, 8'h11, 8'h22, 8'd4);
      add(1, 8'h44, 1, 1, 8'h33, 8'h44, 8'd5);
      // sparse 10,20,30 then 40,50
      add(1, 8'h10, 0, 0, 8'h33, 8'h44, 8'd5);
      add(0, 8'h00, 0, 0, 8'h33, 8'h44, 8'd5);
      add(1, 8'h20, 1, 1, 8'h10, 8'h20, 8'd6);
      add(0, 8'h00, 0, 0, 8'h10, 8'h20, 8'd6);
      add(1, 8'h30, 0, 0, 8'h10, 8'h20, 8'd6);
      add(0, 8'h00, 0, 0, 8'h10, 8'h20, 8'd6);
      add(0, 8'h00, 0, 0, 8'h10, 8'h20, 8'd6);
      add(0, 8'h00, 0, 0, 8'h10, 8'h20, 8'd6);
      add(0, 8'h00, 1, 0, 8'h30, 8'h00, 8'd7);
      add(1, 8'h40, 0, 0, 8'h30, 8'h00, 8'd7);
      add(1, 8'h50, 1, 1, 8'h40, 8'h50, 8'd8);

      repeat (2) @(posedge clk_2f);
      #1;
      check_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'd0);
      #4 reset = 1'b0;

      foreach (vq[i]) begin
         valid_in = vq[i].v;
         data_in  = vq[i].v ? vq[i].d : 8'hxx;
         if (vq[i].v) sent.push_back(vq[i].d);
         @(posedge clk_2f);
         #1;
         check_all($sformatf("vec%0d", i), vq[i].ev0, vq[i].ev1, vq[i].ed0, vq[i].ed1, vq[i].ecnt);
         if (valid_stripe_0) recovered.push_back(data_stripe_0);
         if (valid_stripe_1) recovered.push_back(data_stripe_1);
      end
      valid_in = 1'b0;
      data_in  = 8'hxx;

      // Unstripped stream must reproduce the input bytes in order.
      check("sb.length", 32'(recovered.size()), 32'(sent.size()));
      foreach (sent[i]) begin
         exp_b = sent[i];
         if (i < recovered.size()) check($sformatf("sb.byte%0d", i), 32'(recovered[i]), 32'(exp_b));
      end

      // Async reset mid-HALF, no clock edge involved.
      valid_in = 1'b1;
      data_in  = 8'h77;
      @(posedge clk_2f);
      #1;
      valid_in = 1'b0;
      data_in  = 8'hxx;
      #1 reset = 1'b1;
      #1;
      check_all("async_rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'd0);
      #2 reset = 1'b0;
      @(posedge clk_2f);
      #1;
      check("post_rst.valid0", 32'(valid_stripe_0), 32'd0);
      valid_in = 1'b1;
      data_in  = 8'hAA;
      @(posedge clk_2f);
      #1;
      check("aa.valid0", 32'(valid_stripe_0), 32'd0);
      data_in = 8'hBB;
      @(posedge clk_2f);
      #1;
      check_all("aa_bb", 1'b1, 1'b1, 8'hAA, 8'hBB, 8'd1);
      valid_in = 1'b0;
      data_in  = 8'hxx;
      @(posedge clk_2f);
      #1;
      check_all("aa_bb_idle", 1'b0, 1'b0, 8'hAA, 8'hBB, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
